// File: rtl/alu_result_serializer.sv
// Output stage behind the multi-cycle ALU core: captures one wide result and
// streams it LSB chunk first as 1..MAX_BEATS beats with valid/ready on both sides.
module alu_result_serializer #(
   parameter int RESULT_BUS_WIDTH      = 16,
   parameter int RESULT_MAX_DATA_WIDTH = 64,
   parameter int MAX_BEATS             = RESULT_MAX_DATA_WIDTH / RESULT_BUS_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             res_valid,
   output logic                             res_ready,
   input  logic [RESULT_MAX_DATA_WIDTH-1:0] res_data,
   input  logic [2:0]                       res_nbeats,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [RESULT_BUS_WIDTH-1:0]      out_data,
   output logic                             out_last,
   output logic                             busy
);

   localparam int CW = $clog2(MAX_BEATS + 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   state_e                           state_q, state_d;
   logic [RESULT_MAX_DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]                    beats_left_q, beats_left_d;
   logic                             out_valid_q, out_valid_d;
   logic [RESULT_BUS_WIDTH-1:0]      out_data_q, out_data_d;
   logic                             out_last_q, out_last_d;

   logic                             capture;
   logic                             beat_accept;
   logic [CW-1:0]                    n_eff;
   logic [RESULT_MAX_DATA_WIDTH-1:0] shift_next;

   // A consumer taking the final beat frees the stage in the same cycle, so a
   // waiting result can be captured without a bubble.
   assign res_ready   = (state_q == IDLE) || (out_valid_q && out_last_q && out_ready);
   assign capture     = res_valid && res_ready;
   assign beat_accept = out_valid_q && out_ready;
   assign shift_next  = shift_q >> RESULT_BUS_WIDTH;

   always_comb begin
      if (res_nbeats == 3'd0) begin
         n_eff = CW'(1);
      end else if (int'(res_nbeats) > MAX_BEATS) begin
         n_eff = CW'(MAX_BEATS);
      end else begin
         n_eff = CW'(res_nbeats);
      end
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no path leaves a signal unassigned
      // (which would infer a latch) and "hold" is the implicit default.
      state_d      = state_q;
      shift_d      = shift_q;
      beats_left_d = beats_left_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;

      if (beat_accept) begin
         if (out_last_q) begin
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            beats_left_d = '0;
         end else begin
            shift_d      = shift_next;
            out_data_d   = shift_next[RESULT_BUS_WIDTH-1:0];
            beats_left_d = beats_left_q - CW'(1);
            out_last_d   = (beats_left_q == CW'(2));
         end
      end

      // Capture wins over the last-beat teardown above (back-to-back handover).
      if (capture) begin
         state_d      = SEND;
         shift_d      = res_data;
         beats_left_d = n_eff;
         out_valid_d  = 1'b1;
         out_data_d   = res_data[RESULT_BUS_WIDTH-1:0];
         out_last_d   = (n_eff == CW'(1));
      end
   end

   // NOTE: non-blocking assignments here so every flop samples the pre-edge
   // value of every other flop, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         beats_left_q <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         beats_left_q <= beats_left_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed self-checking bench for alu_result_serializer: outputs are sampled
// 1 ns after each rising edge and compared against hand-computed beats.
module tb_alu_result_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;
   logic [2:0]  res_nbeats;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   alu_result_serializer #(
      .RESULT_BUS_WIDTH      (16),
      .RESULT_MAX_DATA_WIDTH (64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_nbeats (res_nbeats),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic beat(input string tag, input logic v, input logic [15:0] d, input logic l, input logic b);
      check({tag, ".valid"}, 64'(out_valid), 64'(v));
      check({tag, ".data"},  64'(out_data),  64'(d));
      check({tag, ".last"},  64'(out_last),  64'(l));
      check({tag, ".busy"},  64'(busy),      64'(b));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [63:0] data, input logic [2:0] nb);
      res_valid  = 1'b1;
      res_data   = data;
      res_nbeats = nb;
   endtask

   initial begin
      rst        = 1'b1;
      res_valid  = 1'b0;
      res_data   = '0;
      res_nbeats = '0;
      out_ready  = 1'b1;

      // Reset state
      #12;
      beat("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
      check("reset.res_ready", 64'(res_ready), 64'd1);
      rst = 1'b0;
      tick();

      // Four-beat result, consumer always ready
      offer(64'h1122_3344_5566_7788, 3'd4);
      #1 check("t1.res_ready_idle", 64'(res_ready), 64'd1);
      tick();
      res_valid = 1'b0;
      beat("t1.b0", 1'b1, 16'h7788, 1'b0, 1'b1);
      tick(); beat("t1.b1", 1'b1, 16'h5566, 1'b0, 1'b1);
      tick(); beat("t1.b2", 1'b1, 16'h3344, 1'b0, 1'b1);
      tick(); beat("t1.b3", 1'b1, 16'h1122, 1'b1, 1'b1);
      tick(); beat("t1.idle", 1'b0, 16'h1122, 1'b0, 1'b0);

      // Single beat, then nbeats=0 clamps to the same single beat
      offer(64'hFFFF_FFFF_FFFF_00AB, 3'd1);
      tick();
      res_valid = 1'b0;
      #1;
      beat("t2.n1", 1'b1, 16'h00AB, 1'b1, 1'b1);
      check("t2.res_ready_last", 64'(res_ready), 64'd1);
      tick(); beat("t2.n1_idle", 1'b0, 16'h00AB, 1'b0, 1'b0);
      offer(64'hFFFF_FFFF_FFFF_00AB, 3'd0);
      tick();
      res_valid = 1'b0;
      beat("t2.n0", 1'b1, 16'h00AB, 1'b1, 1'b1);
      tick(); beat("t2.n0_idle", 1'b0, 16'h00AB, 1'b0, 1'b0);

      // Backpressure holds beat 0 stable for three cycles
      out_ready = 1'b0;
      offer(64'h0000_0000_DEAD_BEEF, 3'd2);
      tick();
      res_valid = 1'b0;
      #1;
      beat("t3.hold0", 1'b1, 16'hBEEF, 1'b0, 1'b1);
      check("t3.res_ready0", 64'(res_ready), 64'd0);
      tick();
      beat("t3.hold1", 1'b1, 16'hBEEF, 1'b0, 1'b1);
      check("t3.res_ready1", 64'(res_ready), 64'd0);
      tick();
      beat("t3.hold2", 1'b1, 16'hBEEF, 1'b0, 1'b1);
      check("t3.res_ready2", 64'(res_ready), 64'd0);
      out_ready = 1'b1;
      tick(); beat("t3.b1", 1'b1, 16'hDEAD, 1'b1, 1'b1);
      tick(); beat("t3.idle", 1'b0, 16'hDEAD, 1'b0, 1'b0);

      // Back-to-back: A (2 beats) then B (1 beat) with no bubble
      offer(64'h0000_0000_0001_0002, 3'd2);
      tick();
      offer(64'h0000_0000_0000_0003, 3'd1);
      #1;
      beat("t4.a0", 1'b1, 16'h0002, 1'b0, 1'b1);
      check("t4.res_ready_a0", 64'(res_ready), 64'd0);
      tick();
      beat("t4.a1", 1'b1, 16'h0001, 1'b1, 1'b1);
      check("t4.res_ready_a1", 64'(res_ready), 64'd1);
      tick();
      res_valid = 1'b0;
      beat("t4.b0", 1'b1, 16'h0003, 1'b1, 1'b1);
      tick(); beat("t4.idle", 1'b0, 16'h0003, 1'b0, 1'b0);

      // nbeats=7 clamps to four beats
      offer(64'hAAAA_BBBB_CCCC_DDDD, 3'd7);
      tick();
      res_valid = 1'b0;
      beat("t5.b0", 1'b1, 16'hDDDD, 1'b0, 1'b1);
      tick(); beat("t5.b1", 1'b1, 16'hCCCC, 1'b0, 1'b1);
      tick(); beat("t5.b2", 1'b1, 16'hBBBB, 1'b0, 1'b1);
      tick(); beat("t5.b3", 1'b1, 16'hAAAA, 1'b1, 1'b1);
      tick(); beat("t5.idle", 1'b0, 16'hAAAA, 1'b0, 1'b0);

      // Asynchronous reset mid-result, then a fresh result from beat 0
      offer(64'h0123_4567_89AB_CDEF, 3'd4);
      tick();
      res_valid = 1'b0;
      beat("t6.b0", 1'b1, 16'hCDEF, 1'b0, 1'b1);
      tick();
      beat("t6.b1", 1'b1, 16'h89AB, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      beat("t6.async_rst", 1'b0, 16'h0000, 1'b0, 1'b0);
      #2 rst = 1'b0;
      check("t6.res_ready_rel", 64'(res_ready), 64'd1);
      offer(64'h0000_0000_1234_5678, 3'd2);
      tick();
      res_valid = 1'b0;
      beat("t6.n0", 1'b1, 16'h5678, 1'b0, 1'b1);
      tick(); beat("t6.n1", 1'b1, 16'h1234, 1'b1, 1'b1);
      tick(); beat("t6.idle", 1'b0, 16'h1234, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
